slow_tick_bcd_counter: RTL and testbench

- Downstream consumer of the board clock divider's slow square-wave output.
- Runs entirely in the fast board clock domain. Synchronises the divided clock, edge-detects it into a one-cycle tick, and advances a multi-digit BCD up/down counter on each tick.
- Feeds the seven-segment display driver with packed BCD digits and a terminal-count flag.

---
 rtl/slow_tick_bcd_counter.sv | 103 ++++++++++
 tb/tb_slow_tick_bcd_counter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/slow_tick_bcd_counter.sv
// Multi-digit BCD up/down counter advanced by edges of a slow, asynchronous divided clock.
// Latency: slow_clk first sampled high at cly edge k -> tick from k+2 to k+3, bcd changes at k+3.
// Backpressure: none; ticks arriving while en=0, or coinciding with load, are dropped.
module slow_tick_bcd_counter #(
    parameter int DIGITS     = 4,
    parameter int BOTH_EDGES = 0
) (
    input  logic                  cly,
    input  logic                  rstn,
    input  logic                  slow_clk,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  tick,
    output logic                  tc,
    output logic                  load_err
);

    logic                sync1;
    logic                sync2;
    logic                prev;
    logic                slow_edge;
    logic [4*DIGITS-1:0] bcd_inc;
    logic [4*DIGITS-1:0] bcd_dec;
    logic [4*DIGITS-1:0] load_fix;
    logic                load_bad;
    logic                all9;
    logic                all0;
    logic                carry;
    logic                borrow;
    logic [3:0]          dig;
    logic [3:0]          ld_dig;

    assign slow_edge = (BOTH_EDGES != 0) ? (sync2 ^ prev) : (sync2 & ~prev);

    // Carry and borrow ripple through every digit in one cycle; invalid load digits become 0.
    always_comb begin
        carry    = 1'b1;
        borrow   = 1'b1;
        bcd_inc  = bcd;
        bcd_dec  = bcd;
        load_fix = '0;
        load_bad = 1'b0;
        all9     = 1'b1;
        all0     = 1'b1;
        dig      = '0;
        ld_dig   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig    = bcd[4*i +: 4];
            ld_dig = load_val[4*i +: 4];
            if (carry) begin
                if (dig == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = dig + 4'd1;
                    carry             = 1'b0;
                end
            end
            if (borrow) begin
                if (dig == 4'd0) begin
                    bcd_dec[4*i +: 4] = 4'd9;
                end else begin
                    bcd_dec[4*i +: 4] = dig - 4'd1;
                    borrow            = 1'b0;
                end
            end
            if (ld_dig > 4'd9) begin
                load_bad = 1'b1;
            end else begin
                load_fix[4*i +: 4] = ld_dig;
            end
            all9 = all9 & (dig == 4'd9);
            all0 = all0 & (dig == 4'd0);
        end
    end

    assign tc = en & (up ? all9 : all0);

    always_ff @(posedge cly or negedge rstn) begin
        if (!rstn) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            prev     <= 1'b0;
            tick     <= 1'b0;
            bcd      <= '0;
            load_err <= 1'b0;
        end else begin
            sync1 <= slow_clk;
            sync2 <= sync1;
            prev  <= sync2;
            tick  <= slow_edge;
            if (load) begin
                bcd      <= load_fix;
                load_err <= load_bad;
            end else if (en && tick) begin
                bcd <= up ? bcd_inc : bcd_dec;
            end
        end
    end

endmodule

// File: tb/tb_slow_tick_bcd_counter.sv
// Scoreboard bench for slow_tick_bcd_counter: rising-edge-only and both-edge instances against an integer model.
module tb_slow_tick_bcd_counter;

    localparam int D   = 4;
    localparam int W   = 4 * D;
    localparam int MOD = 10000;

    logic         cly = 1'b0;
    logic         rstn = 1'b0;
    logic         slow_clk = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;

    logic [W-1:0] bcd_a, bcd_b;
    logic         tick_a, tick_b, tc_a, tc_b, err_a, err_b;

    always #5 cly = ~cly;

    slow_tick_bcd_counter #(.DIGITS(D), .BOTH_EDGES(0)) dut_a (
        .cly(cly), .rstn(rstn), .slow_clk(slow_clk), .en(en), .up(up), .load(load),
        .load_val(load_val), .bcd(bcd_a), .tick(tick_a), .tc(tc_a), .load_err(err_a)
    );

    slow_tick_bcd_counter #(.DIGITS(D), .BOTH_EDGES(1)) dut_b (
        .cly(cly), .rstn(rstn), .slow_clk(slow_clk), .en(en), .up(up), .load(load),
        .load_val(load_val), .bcd(bcd_b), .tick(tick_b), .tc(tc_b), .load_err(err_b)
    );

    typedef struct {
        logic [W-1:0] bcd;
        logic         tick;
        logic         tc;
        logic         err;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state: count as a plain integer, pending tick and error flag per instance,
    // plus the history of slow_clk values seen at each cly edge (index 0 = newest).
    int   cnt[2];
    bit   tk[2];
    bit   er[2];
    bit   samp[$];

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        int           x = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            cnt[i] = 0;
            tk[i]  = 1'b0;
            er[i]  = 1'b0;
        end
        samp = {1'b0, 1'b0, 1'b0, 1'b0};
    endtask

    // What happens at one cly edge, given the inputs present just before it.
    task automatic model_edge();
        int  lv_int;
        bit  lv_bad;
        int  wgt;
        int  d;
        bit  old_tick;
        if (!rstn) begin
            reset_model();
            return;
        end
        samp.push_front(slow_clk);
        while (samp.size() > 4) void'(samp.pop_back());
        lv_int = 0;
        lv_bad = 1'b0;
        wgt    = 1;
        for (int i = 0; i < D; i++) begin
            d = int'(load_val[4*i +: 4]);
            if (d > 9) begin
                lv_bad = 1'b1;
                d = 0;
            end
            lv_int = lv_int + d * wgt;
            wgt    = wgt * 10;
        end
        for (int i = 0; i < 2; i++) begin
            old_tick = tk[i];
            if (load) begin
                cnt[i] = lv_int;
                er[i]  = lv_bad;
            end else if (en && old_tick) begin
                cnt[i] = up ? (cnt[i] + 1) % MOD : (cnt[i] + MOD - 1) % MOD;
            end
            // A slow_clk level change shows up as a tick two edges after it was first sampled.
            if (i == 0) tk[i] = samp[2] && !samp[3];
            else        tk[i] = samp[2] != samp[3];
        end
    endtask

    function automatic exp_t make_exp(input int k);
        exp_t e;
        e.bcd  = to_bcd(cnt[k]);
        e.tick = tk[k];
        e.err  = er[k];
        e.tc   = en && (up ? (cnt[k] == MOD - 1) : (cnt[k] == 0));
        return e;
    endfunction

    // One cly cycle: model the edge, then drive the next inputs and queue what the DUT must show.
    task automatic step(input logic n_rst, input logic n_slow, input logic n_en,
                        input logic n_up, input logic n_load, input logic [W-1:0] n_lv);
        @(posedge cly);
        model_edge();
        #1;
        rstn     = n_rst;
        slow_clk = n_slow;
        en       = n_en;
        up       = n_up;
        load     = n_load;
        load_val = n_lv;
        if (!n_rst) reset_model();
        qa.push_back(make_exp(0));
        qb.push_back(make_exp(1));
    endtask

    task automatic pulse(input logic p_en, input logic p_up);
        repeat (4) step(1'b1, 1'b1, p_en, p_up, 1'b0, '0);
        repeat (4) step(1'b1, 1'b0, p_en, p_up, 1'b0, '0);
    endtask

    task automatic do_load(input logic [W-1:0] v, input logic l_en, input logic l_up);
        step(1'b1, slow_clk, l_en, l_up, 1'b1, v);
        step(1'b1, slow_clk, l_en, l_up, 1'b0, '0);
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t ea;
        exp_t eb;
        forever begin
            @(negedge cly);
            if (qa.size() > 0 && qb.size() > 0) begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                chk("bcd_rise",  bcd_a,       ea.bcd);
                chk("tick_rise", W'(tick_a),  W'(ea.tick));
                chk("tc_rise",   W'(tc_a),    W'(ea.tc));
                chk("err_rise",  W'(err_a),   W'(ea.err));
                chk("bcd_both",  bcd_b,       eb.bcd);
                chk("tick_both", W'(tick_b),  W'(eb.tick));
                chk("tc_both",   W'(tc_b),    W'(eb.tc));
                chk("err_both",  W'(err_b),   W'(eb.err));
            end
        end
    end

    initial begin : stimulus
        logic         r_slow;
        logic         r_en;
        logic         r_up;
        logic         r_load;
        logic [W-1:0] r_lv;
        int           hold;
        reset_model();
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);

        // Count to 0042, then reset between edges mid-operation.
        do_load(16'h0041, 1'b1, 1'b1);
        pulse(1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
        repeat (4) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0);

        // Latency and edge selection from 0000.
        pulse(1'b1, 1'b1);

        // Carry, wrap, borrow.
        do_load(16'h0999, 1'b1, 1'b1);
        pulse(1'b1, 1'b1);
        do_load(16'h9999, 1'b1, 1'b1);
        pulse(1'b1, 1'b1);
        do_load(16'h1000, 1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        do_load(16'h0000, 1'b1, 1'b0);
        pulse(1'b1, 1'b0);

        // Load coinciding with the tick: tick dropped, invalid digit loads as 0.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h12A4);
        repeat (4) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        do_load(16'h0005, 1'b0, 1'b1);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);

        // Enable gating.
        do_load(16'h0300, 1'b0, 1'b1);
        repeat (5) pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b1);

        // Randomised traffic.
        r_slow = 1'b0;
        hold   = 0;
        for (int n = 0; n < 600; n++) begin
            if (hold == 0) begin
                r_slow = ~r_slow;
                hold   = $urandom_range(8, 2);
            end
            hold   = hold - 1;
            r_en   = ($urandom_range(9, 0) < 8);
            r_up   = ($urandom_range(1, 0) == 1);
            r_load = ($urandom_range(19, 0) == 0);
            r_lv   = ($urandom_range(1, 0) == 1) ? W'($urandom) : to_bcd($urandom_range(MOD - 1, 0));
            if ($urandom_range(3, 0) == 0) r_lv = to_bcd($urandom_range(1, 0) == 1 ? MOD - 1 : 0);
            step(1'b1, r_slow, r_en, r_up, r_load, r_lv);
        end

        @(negedge cly);
        @(negedge cly);
        n_cmp++;
        if (qa.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", qa.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
